// File: rtl/rsa_word_packer.sv
// rtl/rsa_word_packer.sv - packs PS/2 bytes into big-endian words for the rsa input stream
module rsa_word_packer #(
   parameter int BYTES = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [7:0]                 ps2_data_i,
   input  logic                       ps2_valid_i,
   input  logic                       ps2_done,
   input  logic                       ps2_reset,
   output logic [8*BYTES-1:0]         rsa_data_o,
   output logic                       rsa_valid_o,
   input  logic                       rsa_ready_i,
   output logic                       rsa_last_o,
   output logic [$clog2(BYTES)-1:0]   byte_cnt_o,
   output logic                       overflow_o
);

   localparam int W  = 8 * BYTES;
   localparam int CW = $clog2(BYTES);

   // S_WAIT means the assembler holds a complete word that the output slot
   // could not yet take; cnt has already wrapped to 0 in that state.
   typedef enum logic {
      S_ACCUM = 1'b0,
      S_WAIT  = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    acc_q, acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            done_pend_q, done_pend_d;
   logic            wait_last_q, wait_last_d;
   logic            ovf_q, ovf_d;
   logic [W-1:0]    out_data_q, out_data_d;
   logic            out_last_q, out_last_d;
   logic            out_valid_q, out_valid_d;

   logic [W-1:0]    word_w;
   logic [W-1:0]    cap_w;
   logic            slot_free;
   logic            is_full;

   assign slot_free = !out_valid_q || rsa_ready_i;
   assign is_full   = (cnt_q == CW'(BYTES - 1));

   // Assembler contents with the incoming byte dropped into lane cnt (lane 0 is the MSB byte).
   always_comb begin
      word_w = acc_q;
      for (int i = 0; i < BYTES; i++) begin
         if (cnt_q == CW'(i)) begin
            word_w[W-1-8*i -: 8] = ps2_data_i;
         end
      end
      cap_w = ps2_valid_i ? word_w : acc_q;
   end

   // Next-state logic for the assembler FSM and the output word register.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      done_pend_d = done_pend_q;
      wait_last_d = wait_last_q;
      ovf_d       = ovf_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_valid_d = out_valid_q && !rsa_ready_i;

      if (ps2_reset) begin
         // The output register is left alone so an offered word stays stable.
         state_d     = S_ACCUM;
         acc_d       = '0;
         cnt_d       = '0;
         done_pend_d = 1'b0;
         wait_last_d = 1'b0;
         ovf_d       = 1'b0;
      end else begin
         unique case (state_q)
            S_ACCUM: begin
               if (done_pend_q) begin
                  // A flush is waiting for the slot; new bytes have nowhere to go.
                  if (ps2_valid_i) begin
                     ovf_d = 1'b1;
                  end
                  if (slot_free) begin
                     out_data_d  = acc_q;
                     out_last_d  = 1'b1;
                     out_valid_d = 1'b1;
                     acc_d       = '0;
                     cnt_d       = '0;
                     done_pend_d = 1'b0;
                  end
               end else if (ps2_valid_i && is_full) begin
                  // Word complete; a simultaneous done marks this word as the last one.
                  if (slot_free) begin
                     out_data_d  = word_w;
                     out_last_d  = ps2_done;
                     out_valid_d = 1'b1;
                     acc_d       = '0;
                     cnt_d       = '0;
                  end else begin
                     acc_d       = word_w;
                     cnt_d       = '0;
                     wait_last_d = ps2_done;
                     state_d     = S_WAIT;
                  end
               end else if (ps2_done) begin
                  // Flush of a partial (possibly empty) word, including any byte this cycle.
                  if (slot_free) begin
                     out_data_d  = cap_w;
                     out_last_d  = 1'b1;
                     out_valid_d = 1'b1;
                     acc_d       = '0;
                     cnt_d       = '0;
                  end else begin
                     acc_d       = cap_w;
                     cnt_d       = ps2_valid_i ? cnt_q + CW'(1) : cnt_q;
                     done_pend_d = 1'b1;
                  end
               end else if (ps2_valid_i) begin
                  acc_d = word_w;
                  cnt_d = cnt_q + CW'(1);
               end
            end

            S_WAIT: begin
               if (ps2_valid_i) begin
                  ovf_d = 1'b1;
               end
               if (ps2_done) begin
                  done_pend_d = 1'b1;
               end
               if (slot_free) begin
                  out_data_d  = acc_q;
                  out_last_d  = wait_last_q;
                  out_valid_d = 1'b1;
                  acc_d       = '0;
                  cnt_d       = '0;
                  wait_last_d = 1'b0;
                  state_d     = S_ACCUM;
               end
            end

            default: begin
               state_d = S_ACCUM;
            end
         endcase
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_ACCUM;
         acc_q       <= '0;
         cnt_q       <= '0;
         done_pend_q <= 1'b0;
         wait_last_q <= 1'b0;
         ovf_q       <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         done_pend_q <= done_pend_d;
         wait_last_q <= wait_last_d;
         ovf_q       <= ovf_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign rsa_data_o  = out_data_q;
   assign rsa_last_o  = out_last_q;
   assign rsa_valid_o = out_valid_q;
   assign byte_cnt_o  = cnt_q;
   assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_rsa_word_packer.sv
// tb/tb_rsa_word_packer.sv - self-checking bench for rsa_word_packer
module tb_rsa_word_packer;

   logic         clk;
   logic         rst;
   logic [7:0]   ps2_data_i;
   logic         ps2_valid_i;
   logic         ps2_done;
   logic         ps2_reset;
   logic [127:0] rsa_data_o;
   logic         rsa_valid_o;
   logic         rsa_ready_i;
   logic         rsa_last_o;
   logic [3:0]   byte_cnt_o;
   logic         overflow_o;

   int n_cmp = 0;
   int n_err = 0;

   rsa_word_packer #(.BYTES(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .ps2_data_i  (ps2_data_i),
      .ps2_valid_i (ps2_valid_i),
      .ps2_done    (ps2_done),
      .ps2_reset   (ps2_reset),
      .rsa_data_o  (rsa_data_o),
      .rsa_valid_o (rsa_valid_o),
      .rsa_ready_i (rsa_ready_i),
      .rsa_last_o  (rsa_last_o),
      .byte_cnt_o  (byte_cnt_o),
      .overflow_o  (overflow_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         v;
      logic [7:0]   b;
      logic         d;
      logic         rdy;
      logic         ev;
      logic         el;
      logic [3:0]   ec;
      logic [127:0] ed;
   } vec_t;

   vec_t vecs[$];

   // reference model state: a byte queue for the assembler plus one output slot
   logic [7:0]   m_q[$];
   logic         m_valid, m_last, m_pend, m_ovf, m_full_last;
   logic [127:0] m_data;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] b, input logic d, input logic r, input logic rdy);
      ps2_valid_i = v;
      ps2_data_i  = b;
      ps2_done    = d;
      ps2_reset   = r;
      rsa_ready_i = rdy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic v, input logic [7:0] b, input logic d, input logic rdy,
                      input logic ev, input logic el, input logic [3:0] ec, input logic [127:0] ed);
      vec_t t;
      t.v = v; t.b = b; t.d = d; t.rdy = rdy; t.ev = ev; t.el = el; t.ec = ec; t.ed = ed;
      vecs.push_back(t);
   endtask

   function automatic logic [127:0] pack(input logic [7:0] q[$]);
      logic [127:0] w = '0;
      for (int i = 0; i < q.size(); i++) w[127-8*i -: 8] = q[i];
      return w;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_valid = 0; m_last = 0; m_pend = 0; m_ovf = 0; m_full_last = 0; m_data = '0;
   endtask

   task automatic emit(input logic [127:0] w, input logic l);
      m_valid = 1; m_data = w; m_last = l;
      m_q.delete();
   endtask

   // one clock of the model, evaluated from the message-level rules
   task automatic model_step(input logic v, input logic [7:0] b, input logic d, input logic r, input logic rdy);
      logic free;
      free = !m_valid || rdy;
      if (m_valid && rdy) m_valid = 0;
      if (r) begin
         m_q.delete(); m_pend = 0; m_ovf = 0; m_full_last = 0;
      end else if (m_q.size() == 16) begin
         if (v) m_ovf = 1;
         if (d) m_pend = 1;
         if (free) begin emit(pack(m_q), m_full_last); m_full_last = 0; end
      end else if (m_pend) begin
         if (v) m_ovf = 1;
         if (free) begin emit(pack(m_q), 1'b1); m_pend = 0; end
      end else begin
         if (v) m_q.push_back(b);
         if (m_q.size() == 16) begin
            if (free) emit(pack(m_q), d);
            else m_full_last = d;
         end else if (d) begin
            if (free) emit(pack(m_q), 1'b1);
            else m_pend = 1;
         end
      end
   endtask

   function automatic logic [3:0] model_cnt();
      return (m_q.size() == 16) ? 4'd0 : 4'(m_q.size());
   endfunction

   initial begin
      drive(0, 8'h00, 0, 0, 1);
      rst = 1'b0;

      // ---- reset ----
      repeat (3) tick();
      check("reset_valid", rsa_valid_o, 0);
      check("reset_data", rsa_data_o, 0);
      check("reset_last", rsa_last_o, 0);
      check("reset_cnt", byte_cnt_o, 0);
      check("reset_ovf", overflow_o, 0);
      rst = 1'b1;
      tick();
      check("post_reset_valid", rsa_valid_o, 0);
      check("post_reset_cnt", byte_cnt_o, 0);

      // ---- 16 bytes 0x00..0x0F with ready high ----
      for (int i = 0; i < 16; i++) begin
         drive(1, 8'(i), 0, 0, 1);
         tick();
         if (i < 15) check("seq16_no_early_valid", rsa_valid_o, 0);
      end
      check("seq16_valid", rsa_valid_o, 1);
      check("seq16_data", rsa_data_o, 128'h000102030405060708090A0B0C0D0E0F);
      check("seq16_last", rsa_last_o, 0);
      check("seq16_cnt", byte_cnt_o, 0);
      drive(0, 8'h00, 0, 0, 1);
      tick();
      check("seq16_one_cycle", rsa_valid_o, 0);

      // ---- table: partial flush, terminator, 16th byte with done ----
      add(1, 8'hAA, 0, 1, 0, 0, 4'd1, '0);
      add(1, 8'hBB, 0, 1, 0, 0, 4'd2, '0);
      add(0, 8'h00, 1, 1, 1, 1, 4'd0, 128'hAABB0000000000000000000000000000);
      add(0, 8'h00, 1, 1, 1, 1, 4'd0, 128'h0);
      add(0, 8'h00, 0, 1, 0, 0, 4'd0, '0);
      for (int i = 0; i < 15; i++) add(1, 8'(8'h40 + i), 0, 1, 0, 0, 4'(i + 1), '0);
      add(1, 8'h5A, 1, 1, 1, 1, 4'd0, 128'h404142434445464748494A4B4C4D4E5A);
      add(0, 8'h00, 0, 1, 0, 0, 4'd0, '0);
      add(0, 8'h00, 0, 1, 0, 0, 4'd0, '0);
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].v, vecs[i].b, vecs[i].d, 0, vecs[i].rdy);
         tick();
         check($sformatf("vec%0d_valid", i), rsa_valid_o, vecs[i].ev);
         check($sformatf("vec%0d_cnt", i), byte_cnt_o, vecs[i].ec);
         if (vecs[i].ev) begin
            check($sformatf("vec%0d_data", i), rsa_data_o, vecs[i].ed);
            check($sformatf("vec%0d_last", i), rsa_last_o, vecs[i].el);
         end
      end

      // ---- 33 bytes with ready low: backpressure and overflow ----
      for (int i = 1; i <= 33; i++) begin
         drive(1, 8'(i), 0, 0, 0);
         tick();
         if (i == 16) check("bp_first_valid", rsa_valid_o, 1);
         if (i == 20) check("bp_cnt_mid", byte_cnt_o, 4);
         if (i == 32) check("bp_ovf_not_yet", overflow_o, 0);
      end
      check("bp_held_data", rsa_data_o, 128'h0102030405060708090A0B0C0D0E0F10);
      check("bp_held_valid", rsa_valid_o, 1);
      check("bp_wait_cnt", byte_cnt_o, 0);
      check("bp_ovf", overflow_o, 1);
      drive(0, 8'h00, 0, 0, 1);
      tick();
      check("bp_second_valid", rsa_valid_o, 1);
      check("bp_second_data", rsa_data_o, 128'h1112131415161718191A1B1C1D1E1F20);
      check("bp_second_last", rsa_last_o, 0);
      tick();
      check("bp_drained", rsa_valid_o, 0);
      check("bp_ovf_sticky", overflow_o, 1);

      // ---- ps2_reset during an offered word ----
      for (int i = 0; i < 16; i++) begin
         drive(1, 8'(8'h60 + i), 0, 0, 0);
         tick();
      end
      for (int i = 0; i < 5; i++) begin
         drive(1, 8'hEE, 0, 0, 0);
         tick();
      end
      check("prst_cnt5", byte_cnt_o, 5);
      drive(1, 8'hEE, 1, 1, 0);
      tick();
      check("prst_cnt", byte_cnt_o, 0);
      check("prst_ovf_clear", overflow_o, 0);
      check("prst_valid_kept", rsa_valid_o, 1);
      check("prst_data_kept", rsa_data_o, 128'h606162636465666768696A6B6C6D6E6F);
      drive(0, 8'h00, 0, 0, 1);
      tick();
      check("prst_consumed", rsa_valid_o, 0);
      for (int i = 0; i < 16; i++) begin
         drive(1, 8'(8'h80 + i), 0, 0, 1);
         tick();
      end
      check("prst_clean_valid", rsa_valid_o, 1);
      check("prst_clean_data", rsa_data_o, 128'h808182838485868788898A8B8C8D8E8F);
      check("prst_clean_last", rsa_last_o, 0);

      // ---- asynchronous rst mid-word ----
      drive(1, 8'h33, 0, 0, 0);
      tick();
      tick();
      drive(0, 8'h00, 0, 0, 0);
      #2 rst = 1'b0;
      #1;
      check("async_rst_cnt", byte_cnt_o, 0);
      check("async_rst_valid", rsa_valid_o, 0);
      tick();
      rst = 1'b1;

      // ---- randomized traffic against the reference model ----
      model_reset();
      for (int c = 0; c < 4000; c++) begin
         logic v, d, r, rdy;
         logic [7:0] b;
         v   = ($urandom_range(0, 99) < 55);
         b   = 8'($urandom);
         d   = ($urandom_range(0, 99) < 6);
         r   = ($urandom_range(0, 199) < 1);
         rdy = ($urandom_range(0, 99) < ((c / 500) % 2 == 0 ? 70 : 25));
         drive(v, b, d, r, rdy);
         model_step(v, b, d, r, rdy);
         tick();
         check("rnd_valid", rsa_valid_o, m_valid);
         check("rnd_cnt", byte_cnt_o, model_cnt());
         check("rnd_ovf", overflow_o, m_ovf);
         if (m_valid) begin
            check("rnd_data", rsa_data_o, m_data);
            check("rnd_last", rsa_last_o, m_last);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
